switch_bounce_emulator: RTL

Generates a realistic bouncing switch waveform from a clean, synchronous level. On every level change it emits a burst of pseudo-random glitches of bounded duration, then settles to the new level. It drives the existing switch debouncer on-chip for self-test and bench stimulus: the emitting end of the noisy-switch interface the debouncer consumes.

---
 rtl/bounce_pkg.sv | 15 +
 rtl/lfsr_galois.sv | 42 ++++
 rtl/switch_bounce_emulator.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bounce_pkg.sv
// Shared state type and LFSR constants for the switch bounce emulator.
package bounce_pkg;

  // The pseudo-random source is a 16-bit Galois LFSR for
  // x^16 + x^14 + x^13 + x^11 + 1.
  localparam int                   LFSR_BITS = 16;
  localparam logic [LFSR_BITS-1:0] LFSR_MASK = 16'hB400;

  // IDLE: output follows the settled level. BOUNCE: a burst is in progress.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } t_bounce_state;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR. It advances on every clock while out of reset.
// An all-zero seed would lock the register at zero, so it is replaced by 1.
module lfsr_galois
  import bounce_pkg::*;
#(
  parameter int               WIDTH = LFSR_BITS,
  parameter logic [WIDTH-1:0] MASK  = LFSR_MASK,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             in_clk,
  input  logic             in_rst,
  output logic [WIDTH-1:0] out_value
);

  localparam logic [WIDTH-1:0] SEED_EFF =
    (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_next;

  // Shift right and fold the mask back in when a one falls out of the low end.
  always_comb begin
    w_next = {1'b0, r_value[WIDTH-1:1]};
    if (r_value[0]) begin
      w_next = w_next ^ MASK;
    end else begin
      w_next = w_next;
    end
  end

  // State register. The asynchronous reset restores the seed.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_value <= SEED_EFF;
    end else begin
      r_value <= w_next;
    end
  end

  assign out_value = r_value;

endmodule

// File: rtl/switch_bounce_emulator.sv
// Switch bounce emulator. It turns a clean level into a bouncing switch waveform.
// Each level change produces a burst of random-length segments that lasts
// BOUNCE_TICKS cycles. The output is then forced to the new level.
// When in_enable is low, the output is a one-cycle registered copy of in_signal.
module switch_bounce_emulator
  import bounce_pkg::*;
#(
  parameter int                   BOUNCE_TICKS = 40,
  parameter int                   SEG_BITS     = 3,
  parameter logic [LFSR_BITS-1:0] SEED         = 16'hACE1,
  parameter int                   CNT_BITS     = $clog2(BOUNCE_TICKS) + 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_signal,
  input  logic                in_enable,
  output logic                out_bouncy,
  output logic                out_busy,
  output logic [CNT_BITS-1:0] out_toggles
);

  localparam logic [CNT_BITS-1:0] WIN_LOAD = CNT_BITS'(BOUNCE_TICKS - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] TOG_MAX  = {CNT_BITS{1'b1}};
  localparam logic [SEG_BITS-1:0] SEG_ZERO = {SEG_BITS{1'b0}};
  localparam logic [SEG_BITS-1:0] SEG_ONE  = {{(SEG_BITS-1){1'b0}}, 1'b1};

  // Toggle counter increment that saturates at all-ones.
  function automatic logic [CNT_BITS-1:0] tog_inc(input logic [CNT_BITS-1:0] v);
    if (v == TOG_MAX) begin
      tog_inc = v;
    end else begin
      tog_inc = v + CNT_ONE;
    end
  endfunction

  t_bounce_state        r_state;
  t_bounce_state        w_state_nxt;
  logic                 r_level;
  logic                 w_level_nxt;
  logic                 r_target;
  logic                 w_target_nxt;
  logic                 r_bouncy;
  logic                 w_bouncy_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic [CNT_BITS-1:0]  r_win;
  logic [CNT_BITS-1:0]  w_win_nxt;
  logic [SEG_BITS-1:0]  r_seg;
  logic [SEG_BITS-1:0]  w_seg_nxt;
  logic [CNT_BITS-1:0]  r_tog;
  logic [CNT_BITS-1:0]  w_tog_nxt;
  logic [LFSR_BITS-1:0] w_lfsr;
  logic [SEG_BITS-1:0]  w_seg_load;
  logic                 w_unused_lfsr;

  lfsr_galois #(
    .WIDTH (LFSR_BITS),
    .MASK  (LFSR_MASK),
    .SEED  (SEED)
  ) u_lfsr (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .out_value (w_lfsr)
  );

  // Only the low bits choose segment lengths. The rest of the word is unused.
  assign w_seg_load    = w_lfsr[SEG_BITS-1:0];
  assign w_unused_lfsr = &{1'b0, w_lfsr[LFSR_BITS-1:SEG_BITS]};

  // Next-state and datapath decisions. Every register defaults to holding its value.
  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_bouncy_nxt = r_bouncy;
    w_busy_nxt   = r_busy;
    w_win_nxt    = r_win;
    w_seg_nxt    = r_seg;
    w_tog_nxt    = r_tog;

    if (!in_enable) begin
      // Pass-through: the output mirrors the input and any burst is abandoned.
      // The toggle count keeps its last value.
      w_state_nxt  = IDLE;
      w_level_nxt  = in_signal;
      w_target_nxt = in_signal;
      w_bouncy_nxt = in_signal;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_bouncy_nxt = r_level;
          w_busy_nxt   = 1'b0;
          if (in_signal != r_level) begin
            // First contact: the output jumps to the new level at once.
            w_level_nxt  = in_signal;
            w_target_nxt = in_signal;
            w_bouncy_nxt = in_signal;
            w_win_nxt    = WIN_LOAD;
            w_seg_nxt    = w_seg_load;
            w_tog_nxt    = CNT_ONE;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = BOUNCE;
          end else begin
            w_state_nxt = IDLE;
          end
        end

        BOUNCE: begin
          if (in_signal != r_level) begin
            // A new edge arrived mid-burst. Make first contact with the new
            // level and restart the whole window.
            w_level_nxt  = in_signal;
            w_target_nxt = in_signal;
            w_bouncy_nxt = in_signal;
            w_win_nxt    = WIN_LOAD;
            w_seg_nxt    = w_seg_load;
            if (r_bouncy != in_signal) begin
              w_tog_nxt = CNT_ONE;
            end else begin
              w_tog_nxt = r_tog;
            end
          end else if (r_win == CNT_ZERO) begin
            // The window has expired. Settle on the target level.
            w_bouncy_nxt = r_target;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = IDLE;
            if (r_bouncy != r_target) begin
              w_tog_nxt = tog_inc(r_tog);
            end else begin
              w_tog_nxt = r_tog;
            end
          end else begin
            w_win_nxt = r_win - CNT_ONE;
            if (r_seg == SEG_ZERO) begin
              w_bouncy_nxt = ~r_bouncy;
              w_seg_nxt    = w_seg_load;
              w_tog_nxt    = tog_inc(r_tog);
            end else begin
              w_seg_nxt = r_seg - SEG_ONE;
            end
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Level, counter and output registers.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_level  <= 1'b0;
      r_target <= 1'b0;
      r_bouncy <= 1'b0;
      r_busy   <= 1'b0;
      r_win    <= CNT_ZERO;
      r_seg    <= SEG_ZERO;
      r_tog    <= CNT_ZERO;
    end else begin
      r_level  <= w_level_nxt;
      r_target <= w_target_nxt;
      r_bouncy <= w_bouncy_nxt;
      r_busy   <= w_busy_nxt;
      r_win    <= w_win_nxt;
      r_seg    <= w_seg_nxt;
      r_tog    <= w_tog_nxt;
    end
  end

  assign out_bouncy  = r_bouncy;
  assign out_busy    = r_busy;
  assign out_toggles = r_tog;

endmodule
